// File: rtl/key_pkg.sv
// Shared key-path types and helpers: FSM state encoding plus one-hot
// decode utilities used by the event queue and the upstream edge detector.
package key_pkg;

  localparam int unsigned KEY_W  = 8;
  localparam int unsigned CODE_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    PUSH = 2'd2
  } state_e;

  // True when exactly one bit of the key bus is set.
  function automatic logic is_onehot(input logic [KEY_W-1:0] k);
    return (k != '0) && ((k & (k - KEY_W'(1))) == '0);
  endfunction

  // Bit position of a one-hot key; result is meaningless for non-one-hot input.
  function automatic logic [CODE_W-1:0] onehot_to_idx(input logic [KEY_W-1:0] k);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < KEY_W; i++) begin
      if (k[i]) idx = idx | CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word that
// holds its last value while empty.
module key_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push_c, do_pop_c;

  // A pop frees the slot a full-queue push needs; a pop on empty is dropped.
  always_comb begin
    do_pop_c  = pop && !empty_q;
    do_push_c = push && (!full_q || pop);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dout_d    = dout_q;
    if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push_c, do_pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Head register: next stored word, bypassed input, or held value.
    if (do_pop_c) begin
      if (count_q > CNT_W'(1)) dout_d = mem_q[rd_ptr_d];
      else if (do_push_c)      dout_d = din;
    end else if (do_push_c && empty_q) begin
      dout_d = din;
    end
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign dout  = dout_q;
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/key_event_queue.sv
// Times single-key presses in tick units and queues {code, duration} records
// on release for the playback/game logic to drain.
module key_event_queue
  import key_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DUR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             key,
  input  logic                   press_pulse,
  input  logic                   tick,
  input  logic                   pop,
  output logic                   valid,
  output logic [2:0]             code,
  output logic [DUR_W-1:0]       dur,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   overflow
);

  localparam int unsigned REC_W = CODE_W + DUR_W;
  localparam logic [DUR_W-1:0] DUR_MAX = '1;

  state_e            state_q, state_d;
  logic [CODE_W-1:0] cur_code_q, cur_code_d;
  logic [DUR_W-1:0]  cur_dur_q, cur_dur_d;
  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;
  logic              key_match_c;
  logic              fifo_push_c;
  logic              fifo_full;
  logic              fifo_empty;
  logic [REC_W-1:0]  fifo_dout;

  assign key_match_c = (key == (KEY_W'(1) << cur_code_q));

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cur_code_q <= '0;
      cur_dur_q  <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_code_q <= cur_code_d;
      cur_dur_q  <= cur_dur_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  // Next state and hold-duration counter; ticks on press/release cycles are excluded.
  always_comb begin
    state_d    = state_q;
    cur_code_d = cur_code_q;
    cur_dur_d  = cur_dur_q;
    case (state_q)
      IDLE: begin
        if (press_pulse && is_onehot(key)) begin
          state_d    = HOLD;
          cur_code_d = onehot_to_idx(key);
          cur_dur_d  = '0;
        end
      end
      HOLD: begin
        if (!key_match_c) begin
          state_d = PUSH;
        end else if (tick && (cur_dur_q != DUR_MAX)) begin
          cur_dur_d = cur_dur_q + DUR_W'(1);
        end
      end
      PUSH:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: record push, busy flag, sticky overflow on a dropped record.
  always_comb begin
    fifo_push_c = 1'b0;
    busy_d      = 1'b0;
    overflow_d  = overflow_q;
    if (state_q == PUSH) begin
      fifo_push_c = 1'b1;
      if (fifo_full && !pop) overflow_d = 1'b1;
    end
    if (state_d != IDLE) busy_d = 1'b1;
  end

  key_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push_c),
    .pop   (pop),
    .din   ({cur_code_q, cur_dur_q}),
    .dout  (fifo_dout),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign valid    = ~fifo_empty;
  assign code     = fifo_dout[REC_W-1 -: CODE_W];
  assign dur      = fifo_dout[DUR_W-1:0];
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Randomized and directed bench for key_event_queue against a queue-based
// behavioural model of press timing and FWFT record delivery.
module tb_key_event_queue;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned DUR_W   = 8;
  localparam int          DUR_MAX = (1 << DUR_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [7:0]             key = 8'd0;
  logic                   press_pulse = 1'b0;
  logic                   tick = 1'b0;
  logic                   pop = 1'b0;
  logic                   valid;
  logic [2:0]             code;
  logic [DUR_W-1:0]       dur;
  logic [$clog2(DEPTH):0] count;
  logic                   busy;
  logic                   overflow;

  key_event_queue #(.DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .key         (key),
    .press_pulse (press_pulse),
    .tick        (tick),
    .pop         (pop),
    .valid       (valid),
    .code        (code),
    .dur         (dur),
    .count       (count),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int code;
    int dur;
  } rec_t;

  rec_t mq[$];
  bit   m_started, m_holding, m_pushing, m_ovf;
  int   m_key, m_cnt, m_hcode, m_hdur;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: events advance at each rising edge from the sampled inputs.
  always @(posedge clk) begin : model
    bit   can_pop;
    bit   accept;
    rec_t r;
    rec_t gone;
    if (!rst) begin
      mq.delete();
      m_started = 1'b1;
      m_holding = 1'b0;
      m_pushing = 1'b0;
      m_ovf     = 1'b0;
      m_key     = 0;
      m_cnt     = 0;
      m_hcode   = 0;
      m_hdur    = 0;
    end else begin
      can_pop = pop && (mq.size() > 0);
      accept  = m_pushing && ((mq.size() < DEPTH) || can_pop);
      r.code  = m_key;
      r.dur   = m_cnt;
      if (m_pushing && !accept) m_ovf = 1'b1;
      if (can_pop) gone = mq.pop_front();
      if (accept) mq.push_back(r);
      if (mq.size() > 0) begin
        m_hcode = mq[0].code;
        m_hdur  = mq[0].dur;
      end
      if (m_pushing) begin
        m_pushing = 1'b0;
      end else if (m_holding) begin
        if (key != 8'(1 << m_key)) begin
          m_holding = 1'b0;
          m_pushing = 1'b1;
        end else if (tick) begin
          m_cnt = (m_cnt + 1 > DUR_MAX) ? DUR_MAX : m_cnt + 1;
        end
      end else if (press_pulse && ($countones(key) == 1)) begin
        m_holding = 1'b1;
        m_cnt     = 0;
        for (int i = 0; i < 8; i++) if (key[i]) m_key = i;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_started) begin
      chk("valid", valid, (mq.size() > 0));
      chk("count", count, mq.size());
      chk("busy", busy, (m_holding || m_pushing));
      chk("overflow", overflow, m_ovf);
      chk("code", code, m_hcode);
      chk("dur", dur, m_hdur);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      press_pulse = 1'b0;
      tick        = 1'b0;
      pop         = 1'b0;
    end
  endtask

  task automatic pop_one();
    @(negedge clk);
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
  endtask

  // Press key idx, nt held ticks, release; returns two cycles after release.
  task automatic press(input int idx, input int nt, input bit tp, input bit tr, input bit pop_push);
    @(negedge clk);
    key = 8'(1 << idx); press_pulse = 1'b1; tick = tp; pop = 1'b0;
    repeat (nt) begin
      @(negedge clk);
      press_pulse = 1'b0; tick = 1'b1;
    end
    @(negedge clk);
    press_pulse = 1'b0; key = 8'd0; tick = tr;
    @(negedge clk);
    tick = 1'b0; pop = pop_push;
    @(negedge clk);
    pop = 1'b0;
  endtask

  initial begin
    int exp_code[8];
    int exp_dur[8];

    // Reset and idle
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(20);
    chk("t1_valid", valid, 0);
    chk("t1_count", count, 0);
    chk("t1_busy", busy, 0);
    chk("t1_overflow", overflow, 0);

    // Single press, key 2, 5 ticks; entry appears two cycles after release
    @(negedge clk);
    key = 8'b0000_0100; press_pulse = 1'b1;
    repeat (5) begin
      @(negedge clk);
      press_pulse = 1'b0; tick = 1'b1;
    end
    @(negedge clk);
    tick = 1'b0; key = 8'd0;
    @(negedge clk);
    chk("t2_valid_n1", valid, 0);
    chk("t2_busy_n1", busy, 1);
    @(negedge clk);
    chk("t2_valid_n2", valid, 1);
    chk("t2_code", code, 2);
    chk("t2_dur", dur, 5);
    chk("t2_count", count, 1);
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    chk("t2_valid_pop", valid, 0);
    chk("t2_count_pop", count, 0);

    // Saturation
    press(7, 300, 1'b0, 1'b0, 1'b0);
    chk("t3_code", code, 7);
    chk("t3_dur", dur, 255);
    pop_one();

    // Ticks on press and release cycles are not counted
    press(4, 3, 1'b1, 1'b1, 1'b0);
    chk("t4_code", code, 4);
    chk("t4_dur", dur, 3);
    pop_one();
    chk("t4_count", count, 0);

    // Fill, overflow, then full push with pop in PUSH cycle
    for (int i = 0; i < 8; i++) press(i, i + 1, 1'b0, 1'b0, 1'b0);
    chk("t5_count_full", count, 8);
    chk("t5_ovf_before", overflow, 0);
    press(3, 4, 1'b0, 1'b0, 1'b0);
    chk("t5_count_ovf", count, 8);
    chk("t5_ovf", overflow, 1);
    chk("t5_head_code", code, 0);
    chk("t5_head_dur", dur, 1);
    press(5, 2, 1'b0, 1'b0, 1'b1);
    chk("t5_count_pp", count, 8);
    chk("t5_ovf_pp", overflow, 1);
    for (int k = 0; k < 7; k++) begin
      exp_code[k] = k + 1;
      exp_dur[k]  = k + 2;
    end
    exp_code[7] = 5;
    exp_dur[7]  = 2;
    for (int k = 0; k < 8; k++) begin
      chk("t5_drain_code", code, exp_code[k]);
      chk("t5_drain_dur", dur, exp_dur[k]);
      pop_one();
    end
    chk("t5_drained", count, 0);

    // Reset mid-hold discards the pending record
    press(1, 2, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    key = 8'b0100_0000; press_pulse = 1'b1;
    repeat (3) begin
      @(negedge clk);
      press_pulse = 1'b0; tick = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0; tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("t6_busy", busy, 0);
    chk("t6_count", count, 0);
    chk("t6_overflow", overflow, 0);
    idle(3);
    key = 8'd0;
    idle(4);
    chk("t6_no_entry", count, 0);
    chk("t6_no_valid", valid, 0);
    pop_one();
    chk("t6_pop_empty", count, 0);

    // Randomized traffic with varying consumer rates and rare resets
    for (int seg = 0; seg < 6; seg++) begin
      int pop_pct;
      pop_pct = (seg % 3 == 0) ? 5 : ((seg % 3 == 1) ? 30 : 60);
      for (int c = 0; c < 500; c++) begin
        int r;
        @(negedge clk);
        r = $urandom_range(99);
        if (r < 4)       key = 8'd0;
        else if (r < 10) key = 8'(1 << $urandom_range(7));
        else if (r < 12) key = 8'($urandom);
        press_pulse = ($urandom_range(3) == 0);
        tick        = ($urandom_range(1) == 1);
        pop         = ($urandom_range(99) < pop_pct);
        rst         = ($urandom_range(999) != 0);
      end
    end
    @(negedge clk);
    rst = 1'b1; press_pulse = 1'b0; tick = 1'b0; pop = 1'b0; key = 8'd0;
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
